// File: rtl/fight_pkg.sv
// Shared types and constants between the round scheduler and the fightingGame core.
package fight_pkg;

    localparam int unsigned ACTION_W = 3;

    // Action substituted for a player who misses the turn; also the reset value
    localparam logic [ACTION_W-1:0] IDLE_ACTION = 3'b000;

    // Action codes understood by fightingGame
    localparam logic [ACTION_W-1:0] ACT_IDLE    = 3'b000;
    localparam logic [ACTION_W-1:0] ACT_PUNCH   = 3'b001;
    localparam logic [ACTION_W-1:0] ACT_KICK    = 3'b010;
    localparam logic [ACTION_W-1:0] ACT_BLOCK   = 3'b011;
    localparam logic [ACTION_W-1:0] ACT_JUMP    = 3'b100;
    localparam logic [ACTION_W-1:0] ACT_CROUCH  = 3'b101;
    localparam logic [ACTION_W-1:0] ACT_SPECIAL = 3'b110;
    localparam logic [ACTION_W-1:0] ACT_THROW   = 3'b111;

    localparam int unsigned ROUND_W = 8;

    // Scheduler phase, visible on the phase port
    typedef enum logic [1:0] {
        PH_COLLECT  = 2'd0,
        PH_ISSUE    = 2'd1,
        PH_COOLDOWN = 2'd2,
        PH_OVER     = 2'd3
    } phase_e;

    // Round counter increment that sticks at all-ones
    function automatic logic [ROUND_W-1:0] sat_inc(input logic [ROUND_W-1:0] v);
        return (v == {ROUND_W{1'b1}}) ? v : v + ROUND_W'(1);
    endfunction

endpackage

// File: rtl/player_action_slot.sv
// One player's submission slot: latches the first accepted action of a turn.
module player_action_slot
    import fight_pkg::*;
(
    input  logic                clk,
    input  logic                resetGame,
    input  logic                valid,
    input  logic                ready,
    input  logic [ACTION_W-1:0] action,
    input  logic                clear,
    input  logic                timeoutFill,
    output logic                held,
    output logic [ACTION_W-1:0] slotAction
);

    logic                held_q, held_d;
    logic [ACTION_W-1:0] act_q, act_d;
    logic                accept;
    logic                fill;

    assign accept = valid & ready;
    assign fill   = timeoutFill & ~held_q;
    assign held   = held_q;

    // Action that would be issued if the turn closed on this edge; a same-edge submission wins over the fill
    assign slotAction = accept ? action : (fill ? IDLE_ACTION : act_q);

    // Next-state for the held flag and latched action
    always_comb begin
        held_d = held_q;
        act_d  = act_q;
        if (clear) begin
            held_d = 1'b0;
            act_d  = IDLE_ACTION;
        end else if (accept) begin
            held_d = 1'b1;
            act_d  = action;
        end else if (fill) begin
            act_d  = IDLE_ACTION;
        end
    end

    // Slot registers with synchronous reset
    always_ff @(posedge clk) begin
        if (resetGame) begin
            held_q <= 1'b0;
            act_q  <= IDLE_ACTION;
        end else begin
            held_q <= held_d;
            act_q  <= act_d;
        end
    end

endmodule

// File: rtl/round_scheduler.sv
// Turn sequencer: collects both players' actions, strobes them into the core, then cools down.
module round_scheduler
    import fight_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES  = 16,
    parameter int unsigned COOLDOWN_CYCLES = 4
) (
    input  logic                clk,
    input  logic                resetGame,
    input  logic                p1Valid,
    input  logic [ACTION_W-1:0] p1Action,
    input  logic                p2Valid,
    input  logic [ACTION_W-1:0] p2Action,
    input  logic                firstWin,
    input  logic                secondWin,
    output logic                p1Ready,
    output logic                p2Ready,
    output logic [ACTION_W-1:0] action1,
    output logic [ACTION_W-1:0] action2,
    output logic                actionEnable,
    output logic [ROUND_W-1:0]  roundCount,
    output logic                gameOver,
    output logic [1:0]          phase
);

    localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > COOLDOWN_CYCLES) ? TIMEOUT_CYCLES
                                                                         : COOLDOWN_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] COOLDOWN_LAST = CNT_W'(COOLDOWN_CYCLES - 1);

    phase_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ACTION_W-1:0]  action1_q, action1_d;
    logic [ACTION_W-1:0]  action2_q, action2_d;
    logic                 act_en_q, act_en_d;
    logic [ROUND_W-1:0]   round_q, round_d;
    logic                 over_q, over_d;

    logic                 p1_held, p2_held;
    logic [ACTION_W-1:0]  p1_slot, p2_slot;
    logic                 p1_accept, p2_accept;
    logic                 any_held, both_ready_to_issue;
    logic                 win;
    logic                 in_collect;
    logic                 collect_timeout;
    logic                 cooldown_last;

    // Ready is the only combinational output pair
    assign in_collect = (state_q == PH_COLLECT);
    assign p1Ready    = in_collect & ~p1_held;
    assign p2Ready    = in_collect & ~p2_held;

    assign p1_accept  = p1Valid & p1Ready;
    assign p2_accept  = p2Valid & p2Ready;
    assign any_held   = p1_held | p2_held;
    assign win        = firstWin | secondWin;

    // Turn closes once both players are held, counting the submissions sampled on this edge
    assign both_ready_to_issue = (p1_held | p1_accept) & (p2_held | p2_accept);

    // Timeout window only runs once someone has submitted
    assign collect_timeout = in_collect & any_held & (cnt_q == TIMEOUT_LAST);
    assign cooldown_last   = (state_q == PH_COOLDOWN) & (cnt_q == COOLDOWN_LAST);

    player_action_slot u_slot_p1 (
        .clk         (clk),
        .resetGame   (resetGame),
        .valid       (p1Valid),
        .ready       (p1Ready),
        .action      (p1Action),
        .clear       (cooldown_last),
        .timeoutFill (collect_timeout),
        .held        (p1_held),
        .slotAction  (p1_slot)
    );

    player_action_slot u_slot_p2 (
        .clk         (clk),
        .resetGame   (resetGame),
        .valid       (p2Valid),
        .ready       (p2Ready),
        .action      (p2Action),
        .clear       (cooldown_last),
        .timeoutFill (collect_timeout),
        .held        (p2_held),
        .slotAction  (p2_slot)
    );

    // Next-state and registered-output logic for the scheduler FSM and shared counter
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        action1_d = action1_q;
        action2_d = action2_q;
        act_en_d  = 1'b0;
        round_d   = round_q;
        over_d    = over_q;

        unique case (state_q)
            PH_COLLECT: begin
                if (win) begin
                    state_d = PH_OVER;
                    over_d  = 1'b1;
                    cnt_d   = '0;
                end else if (both_ready_to_issue || collect_timeout) begin
                    state_d   = PH_ISSUE;
                    act_en_d  = 1'b1;
                    action1_d = p1_slot;
                    action2_d = p2_slot;
                    round_d   = sat_inc(round_q);
                    cnt_d     = '0;
                end else if (any_held) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = '0;
                end
            end

            PH_ISSUE: begin
                state_d = PH_COOLDOWN;
                cnt_d   = '0;
            end

            PH_COOLDOWN: begin
                if (cnt_q == COOLDOWN_LAST) begin
                    cnt_d   = '0;
                    state_d = win ? PH_OVER : PH_COLLECT;
                    over_d  = win;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            PH_OVER: begin
                over_d = 1'b1;
            end

            default: begin
                state_d = PH_COLLECT;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (resetGame) begin
            state_q   <= PH_COLLECT;
            cnt_q     <= '0;
            action1_q <= IDLE_ACTION;
            action2_q <= IDLE_ACTION;
            act_en_q  <= 1'b0;
            round_q   <= '0;
            over_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            action1_q <= action1_d;
            action2_q <= action2_d;
            act_en_q  <= act_en_d;
            round_q   <= round_d;
            over_q    <= over_d;
        end
    end

    assign action1      = action1_q;
    assign action2      = action2_q;
    assign actionEnable = act_en_q;
    assign roundCount   = round_q;
    assign gameOver     = over_q;
    assign phase        = 2'(state_q);

endmodule
